// File: rtl/face_detection_ip_core.sv
// Mailbox-driven tile-brightness detector: host streams a frame pixel by pixel, reads back flagged tile origins.
// One-cycle registered response to every write; no backpressure, illegal commands are dropped.
module face_detection_ip_core #(
  parameter int FRAME_WIDTH  = 800,
  parameter int FRAME_HEIGHT = 600,
  parameter int TILE         = 100,
  parameter int THRESHOLD    = 128
) (
  input  logic        s_clk,
  input  logic        s_reset,
  input  logic [2:0]  s_address,
  input  logic        s_read,
  output logic [12:0] s_readdata,
  input  logic        s_write,
  input  logic [12:0] s_writedata,
  output logic [63:0] SEG7
);

  localparam int TX    = FRAME_WIDTH / TILE;
  localparam int TY    = FRAME_HEIGHT / TILE;
  localparam int NT    = TX * TY;
  localparam int TW    = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int TXW   = (TX > 1) ? $clog2(TX) : 1;
  localparam int TYW   = (TY > 1) ? $clog2(TY) : 1;
  localparam int TIW   = $clog2(NT + 1);
  localparam int CW    = $clog2(NT + 1);
  localparam int IW    = $clog2(2 * NT + 2);
  localparam int SUM_W = $clog2(TILE * TILE * 255 + 1);
  localparam int unsigned THR_SUM = THRESHOLD * TILE * TILE;

  localparam logic [TW-1:0]  P_LAST  = TW'(TILE - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX - 1);
  localparam logic [TYW-1:0] TY_LAST = TYW'(TY - 1);

  localparam logic [12:0] CMD_START_PIX  = 13'd1;
  localparam logic [12:0] CMD_STOP_PIX   = 13'd2;
  localparam logic [12:0] CMD_START_RES  = 13'd3;
  localparam logic [12:0] CMD_STOP_RES   = 13'd4;
  localparam logic [12:0] CMD_RESET      = 13'd5;

  localparam logic [3:0] ST_IDLE      = 4'd10;
  localparam logic [3:0] ST_WAIT_PIX  = 4'd11;
  localparam logic [3:0] ST_STOP_PIX  = 4'd12;
  localparam logic [3:0] ST_START_RES = 4'd13;
  localparam logic [3:0] ST_STOP_RES  = 4'd14;
  localparam logic [3:0] ST_FINISH    = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PIX, S_GET_PIX, S_FRAME_DONE,
    S_RES_ACK, S_RES_WORD, S_RES_NEXT, S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         status_q, status_d;
  logic [12:0]        readdata_q, readdata_d;
  logic [TW-1:0]      px_q, px_d, py_q, py_d;
  logic [TXW-1:0]     tx_q, tx_d;
  logic [TYW-1:0]     ty_q, ty_d;
  logic [SUM_W-1:0]   acc_q [TX];
  logic [SUM_W-1:0]   acc_d [TX];
  logic [NT-1:0]      flags_q, flags_d;
  logic               done_q, done_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [TIW-1:0]     cur_q, cur_d;
  logic               armed_q;

  logic               wr;
  logic [CW-1:0]      n_flags;
  logic [12:0]        word;
  logic [7:0]         cnt8;
  logic               unused_inputs;

  assign unused_inputs = ^{s_address, s_read};
  // The first edge after reset release never accepts a write.
  assign wr = s_write & armed_q;

  function automatic logic [TIW-1:0] next_flag(input logic [NT-1:0] f, input logic [TIW-1:0] start);
    next_flag = TIW'(NT);
    for (int i = NT - 1; i >= 0; i--) begin
      if (f[i] && i >= int'(start)) next_flag = TIW'(i);
    end
  endfunction

  function automatic logic [7:0] seg_hex(input logic [3:0] v);
    case (v)
      4'h0: seg_hex = 8'hC0;  4'h1: seg_hex = 8'hF9;  4'h2: seg_hex = 8'hA4;  4'h3: seg_hex = 8'hB0;
      4'h4: seg_hex = 8'h99;  4'h5: seg_hex = 8'h92;  4'h6: seg_hex = 8'h82;  4'h7: seg_hex = 8'hF8;
      4'h8: seg_hex = 8'h80;  4'h9: seg_hex = 8'h90;  4'hA: seg_hex = 8'h88;  4'hB: seg_hex = 8'h83;
      4'hC: seg_hex = 8'hC6;  4'hD: seg_hex = 8'hA1;  4'hE: seg_hex = 8'h86;  default: seg_hex = 8'h8E;
    endcase
  endfunction

  always_comb begin
    n_flags = '0;
    for (int i = 0; i < NT; i++) begin
      if (flags_q[i]) n_flags = n_flags + CW'(1);
    end
  end

  // Word 0 is the count; odd words are x-origins, even words y-origins of cur_q.
  always_comb begin
    word = '0;
    if (idx_q == '0)   word = 13'(n_flags);
    else if (idx_q[0]) word = 13'((int'(cur_q) % TX) * TILE);
    else               word = 13'((int'(cur_q) / TX) * TILE);
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    px_d     = px_q;
    py_d     = py_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    acc_d    = acc_q;
    flags_d  = flags_q;
    done_d   = done_q;
    idx_d    = idx_q;
    cur_d    = cur_q;

    if (state_q == S_RES_ACK) state_d = S_RES_WORD;

    if (wr) begin
      if (state_q == S_GET_PIX) begin
        state_d  = S_WAIT_PIX;
        status_d = ST_WAIT_PIX;
        if (!done_q) begin
          acc_d[tx_q] = acc_q[tx_q] + SUM_W'(s_writedata[7:0]);
          if (px_q == P_LAST && tx_q == TX_LAST && py_q == P_LAST) begin
            for (int c = 0; c < TX; c++) begin
              flags_d[int'(ty_q) * TX + c] = (32'(acc_d[c]) >= THR_SUM);
              acc_d[c] = '0;
            end
          end
          if (px_q != P_LAST) begin
            px_d = px_q + 1'b1;
          end else begin
            px_d = '0;
            if (tx_q != TX_LAST) begin
              tx_d = tx_q + 1'b1;
            end else begin
              tx_d = '0;
              if (py_q != P_LAST) begin
                py_d = py_q + 1'b1;
              end else begin
                py_d = '0;
                if (ty_q != TY_LAST) begin
                  ty_d = ty_q + 1'b1;
                end else begin
                  ty_d   = '0;
                  done_d = 1'b1;
                end
              end
            end
          end
        end
      end else if (s_writedata == CMD_RESET) begin
        state_d  = S_WAIT_PIX;
        status_d = ST_WAIT_PIX;
        px_d     = '0;
        py_d     = '0;
        tx_d     = '0;
        ty_d     = '0;
        for (int c = 0; c < TX; c++) acc_d[c] = '0;
        flags_d  = '0;
        done_d   = 1'b0;
        idx_d    = '0;
        cur_d    = '0;
      end else begin
        case (state_q)
          S_WAIT_PIX: begin
            if (s_writedata == CMD_START_PIX) begin
              state_d  = S_GET_PIX;
              status_d = ST_STOP_PIX;
            end else if (s_writedata == CMD_STOP_PIX && done_q) begin
              state_d  = S_FRAME_DONE;
              status_d = ST_STOP_PIX;
            end
          end
          S_FRAME_DONE, S_RES_NEXT: begin
            if (s_writedata == CMD_START_RES) begin
              state_d  = S_RES_ACK;
              status_d = ST_START_RES;
            end
          end
          S_RES_WORD: begin
            if (s_writedata == CMD_STOP_RES) begin
              idx_d = idx_q + 1'b1;
              if (idx_q == '0)    cur_d = next_flag(flags_q, '0);
              else if (!idx_q[0]) cur_d = next_flag(flags_q, cur_q + 1'b1);
              if (int'(idx_q) + 1 >= 1 + 2 * int'(n_flags)) begin
                state_d  = S_FINISH;
                status_d = ST_FINISH;
              end else begin
                state_d  = S_RES_NEXT;
                status_d = ST_STOP_RES;
              end
            end
          end
          default: ;
        endcase
      end
    end

    readdata_d = (state_d == S_RES_WORD) ? word : 13'(status_d);
  end

  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      state_q    <= S_IDLE;
      status_q   <= ST_IDLE;
      readdata_q <= 13'(ST_IDLE);
      px_q       <= '0;
      py_q       <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
      for (int c = 0; c < TX; c++) acc_q[c] <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      cur_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      readdata_q <= readdata_d;
      px_q       <= px_d;
      py_q       <= py_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      armed_q    <= 1'b1;
    end
  end

  assign cnt8       = 8'(n_flags);
  assign s_readdata = readdata_q;
  assign SEG7       = {32'hFFFF_FFFF, seg_hex(cnt8[7:4]), seg_hex(cnt8[3:0]),
                       seg_hex(4'h0), seg_hex(status_q)};

endmodule

// File: tb/tb_face_detection_ip_core.sv
// Randomized mailbox bench for face_detection_ip_core on a reduced 40x30 frame with 5x5 tiles (still 8x6 tiles).
module tb_face_detection_ip_core;
  localparam int W   = 40;
  localparam int H   = 30;
  localparam int T   = 5;
  localparam int THR = 128;

  logic        s_clk = 1'b0;
  logic        s_reset;
  logic [2:0]  s_address;
  logic        s_read;
  logic [12:0] s_readdata;
  logic        s_write;
  logic [12:0] s_writedata;
  logic [63:0] SEG7;

  int n_checks = 0;
  int n_pass   = 0;
  int frame [H][W];
  int exp_words [$];

  face_detection_ip_core #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .TILE(T), .THRESHOLD(THR)
  ) dut (
    .s_clk(s_clk), .s_reset(s_reset), .s_address(s_address), .s_read(s_read),
    .s_readdata(s_readdata), .s_write(s_write), .s_writedata(s_writedata), .SEG7(SEG7)
  );

  always #5 s_clk = ~s_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] seg(input int v);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[v & 15];
  endfunction

  function automatic logic [63:0] exp_seg(input int status, input int n);
    return {32'hFFFF_FFFF, seg(n / 16), seg(n % 16), seg(0), seg(status)};
  endfunction

  task automatic wr(input int v);
    s_write     = 1'b1;
    s_writedata = 13'(v);
    @(negedge s_clk);
    s_write     = 1'b0;
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) frame[y][x] = v;
  endtask

  task automatic fill_random();
    int base, p;
    for (int ty = 0; ty < H / T; ty++)
      for (int tx = 0; tx < W / T; tx++) begin
        base = int'($urandom_range(112, 144));
        for (int y = 0; y < T; y++)
          for (int x = 0; x < T; x++) begin
            p = base + int'($urandom_range(0, 16)) - 8;
            frame[ty*T+y][tx*T+x] = p;
          end
      end
  endtask

  // Reference: tile sums from the stored frame, flagged origins listed in raster order.
  task automatic build_model();
    int sum, pairs [$];
    pairs.delete();
    exp_words.delete();
    for (int ty = 0; ty < H / T; ty++)
      for (int tx = 0; tx < W / T; tx++) begin
        sum = 0;
        for (int y = 0; y < T; y++)
          for (int x = 0; x < T; x++) sum += frame[ty*T+y][tx*T+x];
        if (sum >= THR * T * T) begin
          pairs.push_back(tx * T);
          pairs.push_back(ty * T);
        end
      end
    exp_words.push_back(pairs.size() / 2);
    foreach (pairs[i]) exp_words.push_back(pairs[i]);
  endtask

  task automatic send_pixels(input int first, input int last);
    for (int p = first; p <= last; p++) begin
      wr(1);
      wr(frame[p / W][p % W]);
      wr(2);
    end
  endtask

  task automatic read_results(input string name);
    for (int i = 0; i < exp_words.size(); i++) begin
      wr(3);
      check_eq($sformatf("%s_ack%0d", name, i), 64'(s_readdata), 64'd13);
      @(negedge s_clk);
      check_eq($sformatf("%s_word%0d", name, i), 64'(s_readdata), 64'(exp_words[i]));
      wr(4);
      check_eq($sformatf("%s_adv%0d", name, i), 64'(s_readdata),
               (i == exp_words.size() - 1) ? 64'd15 : 64'd14);
    end
    check_eq({name, "_seg"}, SEG7, exp_seg(15, exp_words[0]));
  endtask

  task automatic full_frame(input string name);
    build_model();
    send_pixels(0, W * H - 1);
    check_eq({name, "_done"}, 64'(s_readdata), 64'd12);
    read_results(name);
  endtask

  initial begin
    s_reset = 1'b0;
    s_address = '0;
    s_read = 1'b0;
    s_write = 1'b0;
    s_writedata = '0;
    repeat (3) @(negedge s_clk);
    check_eq("rst_status", 64'(s_readdata), 64'd10);
    check_eq("rst_seg", SEG7, 64'hFFFF_FFFF_C0C0_C088);

    s_reset = 1'b1;
    wr(5);
    check_eq("deassert_write_ignored", 64'(s_readdata), 64'd10);
    wr(1);
    check_eq("idle_cmd1_ignored", 64'(s_readdata), 64'd10);
    wr(5);
    check_eq("cmd5_status", 64'(s_readdata), 64'd11);

    // Random frame whose first pixels collide with command codes.
    fill_random();
    frame[0][0] = 2;
    frame[0][1] = 5;
    build_model();
    wr(1);
    check_eq("hs_get_pix", 64'(s_readdata), 64'd12);
    wr(2);
    check_eq("hs_pixel2", 64'(s_readdata), 64'd11);
    wr(2);
    check_eq("hs_stop_early", 64'(s_readdata), 64'd11);
    wr(3);
    check_eq("hs_cmd3_ignored", 64'(s_readdata), 64'd11);
    send_pixels(1, W * H - 1);
    check_eq("rand_done", 64'(s_readdata), 64'd12);
    read_results("rand");
    wr(3);
    check_eq("finish_cmd3_ignored", 64'(s_readdata), 64'd15);

    wr(5);
    fill_const(255);
    build_model();
    send_pixels(0, W * H - 1);
    check_eq("w255_done", 64'(s_readdata), 64'd12);
    wr(4);
    check_eq("w255_cmd4_ignored", 64'(s_readdata), 64'd12);
    wr(1);
    check_eq("w255_cmd1_ignored", 64'(s_readdata), 64'd12);
    check_eq("w255_n", 64'(exp_words.size()), 64'd97);
    read_results("w255");

    wr(5);
    fill_const(0);
    full_frame("zero");

    // Tile (0,0) sums exactly to the threshold, tile (1,0) falls one short.
    wr(5);
    fill_const(127);
    for (int y = 0; y < T; y++)
      for (int x = 0; x < 2 * T; x++) frame[y][x] = 128;
    frame[T-1][2*T-1] = 127;
    full_frame("thr");

    wr(5);
    fill_random();
    send_pixels(0, 999);
    wr(5);
    check_eq("mid_reset", 64'(s_readdata), 64'd11);
    fill_const(255);
    full_frame("after_mid");

    wr(5);
    fill_random();
    full_frame("rand2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
